sdram_rw_test_master: RTL and testbench

Avalon-MM master that exercises the SDRAM through the SDRAM controller's Avalon slave port, the initiating end of the interface the controller responds on.

- On a start pulse it writes a deterministic 16-bit pattern over a configurable word range, reads the range back with pipelined reads, and compares every returned word.
- It runs two passes: true pattern, then inverted pattern.
- It reports busy/done, pass/fail, an error count and the first failing address/data.
- It sits in the Nios II / SDRAM test system beside the CPU as a second master on the controller's slave port.

---
 rtl/sdram_test_pkg.sv | 24 ++
 rtl/sdram_rw_checker.sv | 32 +++
 rtl/sdram_rw_test_master.sv | 165 ++++++++++++++++
 tb/tb_sdram_rw_test_master.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_test_pkg.sv
// Shared types and helpers for the SDRAM read/write test master.
package sdram_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] BE_ALL = 2'b11;

  // Test pattern: low address half XOR high address half XOR seed, inverted on pass 1.
  function automatic logic [15:0] pat(input logic [15:0] addr_lo,
                                      input logic [15:0] addr_hi,
                                      input logic [15:0] seed,
                                      input logic        pass);
    logic [15:0] p;
    p = addr_lo ^ addr_hi ^ seed;
    return pass ? ~p : p;
  endfunction

endpackage

// File: rtl/sdram_rw_checker.sv
// Registered read-data compare: saturating error count and first-error capture.
module sdram_rw_checker #(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              valid,
  input  logic [15:0]       readdata,
  input  logic [15:0]       expected,
  input  logic [ADDR_W-1:0] address,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [15:0]       first_err_data
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (valid && (readdata != expected)) begin
      if (err_count != '1) err_count <= err_count + 16'd1;
      // err_count never returns to zero once set, so it doubles as "no error yet".
      if (err_count == '0) begin
        first_err_addr <= address;
        first_err_data <= readdata;
      end
    end
  end

endmodule

// File: rtl/sdram_rw_test_master.sv
// Avalon-MM master that writes a two-pass pattern over a word range and verifies it with pipelined reads.
module sdram_rw_test_master
  import sdram_test_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned MAX_PENDING = 7,
  parameter logic [15:0] SEED        = 16'hA5C3
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_words,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass_ok,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [15:0]       first_err_data
);

  localparam int unsigned       PEND_W   = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base, base_nx, words, words_nx;
  logic [ADDR_W-1:0] wi, wi_nx, ri, ri_nx, rx, rx_nx;
  logic [PEND_W-1:0] pending, pending_nx;
  logic              pass_idx, pass_idx_nx;
  logic              done_r, done_nx;
  logic              clear;

  logic              rsp, rd_req, rd_acc, wr_acc;
  logic [ADDR_W-1:0] wr_addr, rd_addr, rx_addr;
  logic [15:0]       exp_data;

  assign wr_addr  = base + wi;
  assign rd_addr  = base + ri;
  assign rx_addr  = base + rx;
  assign exp_data = pat(rx_addr[15:0], rx_addr[ADDR_W-1:ADDR_W-16], SEED, pass_idx);

  assign rsp    = avm_readdatavalid && ((state == READ) || (state == DRAIN));
  assign rd_req = (state == READ) && (pending < PEND_MAX) && (ri != words);
  assign rd_acc = rd_req && !avm_waitrequest;
  assign wr_acc = (state == WRITE) && !avm_waitrequest;

  assign avm_write      = (state == WRITE);
  assign avm_read       = rd_req;
  assign avm_address    = avm_write ? wr_addr : (rd_req ? rd_addr : '0);
  assign avm_writedata  = avm_write ? pat(wr_addr[15:0], wr_addr[ADDR_W-1:ADDR_W-16], SEED, pass_idx) : '0;
  assign avm_byteenable = BE_ALL;

  assign busy    = (state != IDLE) && (state != DONE);
  assign done    = done_r;
  assign pass_ok = done_r && (err_count == '0);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state    <= IDLE;
      base     <= '0;
      words    <= '0;
      wi       <= '0;
      ri       <= '0;
      rx       <= '0;
      pending  <= '0;
      pass_idx <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nx;
      base     <= base_nx;
      words    <= words_nx;
      wi       <= wi_nx;
      ri       <= ri_nx;
      rx       <= rx_nx;
      pending  <= pending_nx;
      pass_idx <= pass_idx_nx;
      done_r   <= done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    base_nx     = base;
    words_nx    = words;
    wi_nx       = wi;
    ri_nx       = ri;
    rx_nx       = rx;
    pending_nx  = pending;
    pass_idx_nx = pass_idx;
    done_nx     = done_r;
    clear       = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (state == DONE) state_nx = IDLE;
        if (start) begin
          clear       = 1'b1;
          base_nx     = cfg_base;
          words_nx    = cfg_words;
          wi_nx       = '0;
          ri_nx       = '0;
          rx_nx       = '0;
          pending_nx  = '0;
          pass_idx_nx = 1'b0;
          done_nx     = 1'b0;
          state_nx    = (cfg_words == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (wr_acc) begin
          if (wi + ONE == words) begin
            wi_nx    = '0;
            state_nx = READ;
          end else begin
            wi_nx = wi + ONE;
          end
        end
      end
      READ, DRAIN: begin
        if (rd_acc) ri_nx = ri + ONE;
        if (rsp)    rx_nx = rx + ONE;
        if (rd_acc && !rsp)      pending_nx = pending + PEND_ONE;
        else if (!rd_acc && rsp) pending_nx = pending - PEND_ONE;
        // Completion looks at next-cycle counts so the last response ends the pass without a spare cycle.
        if ((ri_nx == words) && (rx_nx == words)) begin
          if (!pass_idx) begin
            pass_idx_nx = 1'b1;
            ri_nx       = '0;
            rx_nx       = '0;
            state_nx    = WRITE;
          end else begin
            state_nx = DONE;
          end
        end else if (ri_nx == words) begin
          state_nx = DRAIN;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx == DONE) done_nx = 1'b1;
  end

  sdram_rw_checker #(.ADDR_W(ADDR_W)) u_checker (
    .clk            (clk_clk),
    .reset          (reset_reset),
    .clear          (clear),
    .valid          (rsp),
    .readdata       (avm_readdata),
    .expected       (exp_data),
    .address        (rx_addr),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data)
  );

endmodule

// File: tb/tb_sdram_rw_test_master.sv
// Directed bench: behavioural Avalon slave with stall, latency, stuck-bit and corruption knobs.
module tb_sdram_rw_test_master;

  localparam int unsigned AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_base, cfg_words;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [15:0]   avm_writedata;
  logic [1:0]    avm_byteenable;
  logic          avm_waitrequest;
  logic [15:0]   avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic          busy, done, pass_ok;
  logic [15:0]   err_count, first_err_data;
  logic [AW-1:0] first_err_addr;

  always #5 clk = ~clk;

  sdram_rw_test_master #(.MAX_PENDING(2)) dut (
    .clk_clk           (clk),
    .reset_reset       (rst),
    .start             (start),
    .cfg_base          (cfg_base),
    .cfg_words         (cfg_words),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass_ok           (pass_ok),
    .err_count         (err_count),
    .first_err_addr    (first_err_addr),
    .first_err_data    (first_err_data)
  );

  function automatic logic [15:0] exp_pat(input logic [AW-1:0] a, input logic p);
    logic [15:0] v;
    v = a[15:0] ^ a[23:8] ^ 16'hA5C3;
    return p ? ~v : v;
  endfunction

  // Slave knobs, written by the stimulus process only.
  int unsigned lat = 1;
  logic        stall_arm = 1'b0;
  logic        stuck = 1'b0;
  logic        corrupt = 1'b0;
  int unsigned test_wr_base = 0;
  int unsigned test_words = 0;

  typedef struct {
    logic [15:0] d;
    int unsigned due;
  } rsp_t;

  rsp_t          rq[$];
  logic [15:0]   mem[256];
  logic [AW-1:0] wlog[$];
  logic [AW-1:0] rlog[$];
  logic [15:0]   wdlog[$];
  int unsigned   stall_cnt = 0;
  int unsigned   cyc = 0;
  int unsigned   wr_acc_n = 0, rd_acc_n = 0, rdv_n = 0, bus_n = 0, both_n = 0;
  int unsigned   over_n = 0, hit_n = 0, hold_bad = 0, a4_n = 0, wbad_n = 0;
  int            out_n = 0;
  logic          prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [15:0]   prev_data = '0;

  assign avm_waitrequest = stall_arm && avm_write && (avm_address == 24'd4) && (stall_cnt < 3);

  always @(posedge clk) begin
    logic [15:0] d;
    logic        wacc, racc, wpass;
    rsp_t        e;
    wacc = avm_write && !avm_waitrequest;
    racc = avm_read && !avm_waitrequest;
    if (avm_write && avm_waitrequest) stall_cnt <= stall_cnt + 1;
    if (avm_read && avm_write) both_n++;
    if (avm_read || avm_write) bus_n++;
    if (avm_write && (avm_address == 24'd4)) a4_n++;
    if (prev_stall && ((avm_address != prev_addr) || (avm_writedata != prev_data) ||
                       (avm_read != prev_rd) || (avm_write != prev_wr))) hold_bad++;
    prev_stall = (avm_read || avm_write) && avm_waitrequest;
    prev_addr  = avm_address;
    prev_data  = avm_writedata;
    prev_rd    = avm_read;
    prev_wr    = avm_write;
    if (wacc) begin
      wpass = ((wr_acc_n - test_wr_base) >= test_words);
      if (avm_writedata !== exp_pat(avm_address, wpass)) wbad_n++;
      mem[avm_address[7:0]] = avm_writedata;
      wlog.push_back(avm_address);
      wdlog.push_back(avm_writedata);
      wr_acc_n++;
    end
    if (racc) begin
      d = mem[avm_address[7:0]];
      if (stuck && (avm_address == 24'd5)) d = d | 16'h0001;
      e.d   = d;
      e.due = cyc + lat - 1;
      rq.push_back(e);
      rlog.push_back(avm_address);
      rd_acc_n++;
    end
    if (avm_readdatavalid) rdv_n++;
    out_n = out_n + (racc ? 1 : 0) - (avm_readdatavalid ? 1 : 0);
    if (out_n > 2)  over_n++;
    if (out_n == 2) hit_n++;
    avm_readdatavalid <= 1'b0;
    if ((rq.size() > 0) && (rq[0].due == cyc)) begin
      d = rq[0].d;
      if (corrupt) d = ~d;
      avm_readdata      <= d;
      avm_readdatavalid <= 1'b1;
      void'(rq.pop_front());
    end
    cyc++;
  end

  int unsigned n_total = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  int unsigned s_wr, s_rd, s_rdv, s_bus, s_over, s_hit, s_hold, s_a4, s_wbad, s_wlog, s_rlog;

  task automatic snap();
    s_wr = wr_acc_n; s_rd = rd_acc_n; s_rdv = rdv_n; s_bus = bus_n; s_over = over_n;
    s_hit = hit_n; s_hold = hold_bad; s_a4 = a4_n; s_wbad = wbad_n;
    s_wlog = wlog.size(); s_rlog = rlog.size();
  endtask

  task automatic start_test(input logic [AW-1:0] b, input logic [AW-1:0] w);
    @(posedge clk); #1;
    cfg_base     = b;
    cfg_words    = w;
    start        = 1'b1;
    test_wr_base = wr_acc_n;
    test_words   = w;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int unsigned cycles);
    cycles = 1;
    while (!done && (cycles < 3000)) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned   cyc_n, bad, n, rdv_at_rst;
    logic          b1, w1;
    logic [AW-1:0] wrap_exp[4];

    rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_words = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass_ok", pass_ok, 1'b0);
    check("rst_err", err_count, 16'd0);
    check("rst_bus", {avm_read, avm_write, avm_address}, '0);
    check("rst_wdata", avm_writedata, 16'd0);
    check("byteenable", avm_byteenable, 2'b11);
    rst = 1'b0;

    // Zero-wait run: 16 words, 1-cycle read latency.
    snap();
    start_test(24'd0, 24'd16);
    b1 = busy; w1 = avm_write;
    wait_done("zw", cyc_n);
    check("zw_start_busy", b1, 1'b1);
    check("zw_start_write", w1, 1'b1);
    check("zw_cycles", cyc_n, 67);
    check("zw_busy", busy, 1'b0);
    check("zw_pass_ok", pass_ok, 1'b1);
    check("zw_err", err_count, 16'd0);
    check("zw_writes", wr_acc_n - s_wr, 32);
    check("zw_reads", rd_acc_n - s_rd, 32);
    check("zw_wpat", wbad_n - s_wbad, 0);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (wlog[s_wlog + i] != 24'(i % 16)) bad++;
      if (rlog[s_rlog + i] != 24'(i % 16)) bad++;
    end
    check("zw_addr_seq", bad, 0);
    repeat (2) @(posedge clk); #1;
    check("zw_done_hold", {done, pass_ok}, 2'b11);

    // Three-cycle stall on the fifth write.
    stall_arm = 1'b1;
    snap();
    start_test(24'd0, 24'd16);
    wait_done("st", cyc_n);
    stall_arm = 1'b0;
    check("st_cycles", cyc_n, 70);
    check("st_hold", hold_bad - s_hold, 0);
    check("st_addr4_cycles", a4_n - s_a4, 5);
    check("st_writes", wr_acc_n - s_wr, 32);
    bad = 0;
    for (int i = 0; i < 32; i++) if (wlog[s_wlog + i] != 24'(i % 16)) bad++;
    check("st_addr_seq", bad, 0);
    check("st_pass_ok", pass_ok, 1'b1);

    // Three-cycle read latency against the pending limit of 2.
    lat = 3;
    snap();
    start_test(24'd0, 24'd16);
    wait_done("lp", cyc_n);
    lat = 1;
    check("lp_over_limit", over_n - s_over, 0);
    check("lp_limit_hit", (hit_n - s_hit) != 0, 1'b1);
    check("lp_reads", rd_acc_n - s_rd, 32);
    check("lp_pass_ok", pass_ok, 1'b1);

    // Bit 0 stuck at 1 at address 5: only the true-pattern pass can fail.
    stuck = 1'b1;
    snap();
    start_test(24'd0, 24'd16);
    wait_done("sk", cyc_n);
    stuck = 1'b0;
    check("sk_err", err_count, 16'd1);
    check("sk_first_addr", first_err_addr, 24'd5);
    check("sk_first_data", first_err_data, 16'hA5C7);
    check("sk_pass_ok", pass_ok, 1'b0);

    // Zero words: done one cycle after start, bus idle.
    snap();
    start_test(24'h20, 24'd0);
    b1 = busy;
    wait_done("wz", cyc_n);
    check("wz_cycles", cyc_n, 1);
    check("wz_busy", b1, 1'b0);
    check("wz_pass_ok", pass_ok, 1'b1);
    repeat (3) @(posedge clk); #1;
    check("wz_bus_idle", bus_n - s_bus, 0);

    // Address wrap at the top of the space.
    wrap_exp[0] = 24'hFFFFFE; wrap_exp[1] = 24'hFFFFFF; wrap_exp[2] = 24'h000000; wrap_exp[3] = 24'h000001;
    snap();
    start_test(24'hFFFFFE, 24'd4);
    wait_done("wr", cyc_n);
    for (int i = 0; i < 4; i++) check($sformatf("wr_addr%0d", i), wlog[s_wlog + i], wrap_exp[i]);
    check("wr_data0", wdlog[s_wlog], 16'hA5C2);
    check("wr_pass_ok", pass_ok, 1'b1);

    // Start while busy is ignored.
    snap();
    start_test(24'h10, 24'd8);
    repeat (4) @(posedge clk); #1;
    cfg_base = 24'h80; cfg_words = 24'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("sb_busy", busy, 1'b1);
    wait_done("sb", cyc_n);
    check("sb_writes", wr_acc_n - s_wr, 16);
    check("sb_first_addr", wlog[s_wlog], 24'h10);
    check("sb_wpat", wbad_n - s_wbad, 0);
    check("sb_pass_ok", pass_ok, 1'b1);

    // Reset in the middle of reads with two outstanding.
    lat = 3; stuck = 1'b1;
    snap();
    start_test(24'd0, 24'd16);
    n = 0;
    while (!((out_n == 2) && ((rdv_n - s_rdv) >= 8)) && (n < 500)) begin
      @(posedge clk); #1;
      n++;
    end
    check("rr_reached", n < 500, 1'b1);
    check("rr_pre_err", err_count, 16'd1);
    rst = 1'b1; corrupt = 1'b1;
    rdv_at_rst = rdv_n;
    @(posedge clk); #1;
    check("rr_busy", busy, 1'b0);
    check("rr_done_pass", {done, pass_ok}, 2'b00);
    check("rr_err", err_count, 16'd0);
    check("rr_first_addr", first_err_addr, 24'd0);
    check("rr_first_data", first_err_data, 16'd0);
    check("rr_bus", {avm_read, avm_write, avm_address}, '0);
    check("rr_wdata", avm_writedata, 16'd0);
    rst = 1'b0; stuck = 1'b0;
    repeat (8) @(posedge clk); #1;
    check("rr_late_rdv_seen", (rdv_n - rdv_at_rst) != 0, 1'b1);
    check("rr_late_err", err_count, 16'd0);
    check("rr_idle", {busy, done}, 2'b00);
    corrupt = 1'b0; lat = 1;

    // Clean run after the reset.
    snap();
    start_test(24'd0, 24'd16);
    wait_done("ar", cyc_n);
    check("ar_cycles", cyc_n, 67);
    check("ar_pass_ok", pass_ok, 1'b1);
    check("ar_err", err_count, 16'd0);

    check("no_rd_wr_overlap", both_n, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
